// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among
// NUM_REQ valid/ready byte streams. The granted byte is registered and held
// on tx_vld/tx_data until the transmitter accepts it.
// Optional packet locking is enabled by defining UART_ARB_PKT_LOCK_EN: the
// grant then stays on one requester until its req_last byte, and an idle
// lock is forcibly released after LOCK_TIMEOUT cycles (lock_drop pulse).
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_vld,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_rdy,
   output logic                       tx_vld,
   output logic [7:0]                 tx_data,
   input  logic                       tx_rdy,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       busy,
   output logic                       lock_drop
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      LOCK = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [IW-1:0] ptr_reg;
   logic [IW-1:0] ptr_adv;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] sel_idx;
   logic          win_found;
   logic          load;
   logic          release_grant;
   logic [7:0]    req_byte [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_byte
         assign req_byte[gi] = req_data[8*gi +: 8];
      end
   endgenerate

   // Pointer value used when the current grant is released (wraps at NUM_REQ)
   assign ptr_adv = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

`ifdef UART_ARB_PKT_LOCK_EN
   localparam int TW = $clog2(LOCK_TIMEOUT);

   logic          last_reg;
   logic [TW-1:0] timer_reg;
   logic          timeout_hit;

   assign timeout_hit = (timer_reg == TW'(LOCK_TIMEOUT-1));

   // Remember whether the byte in flight closes its packet
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_reg <= 1'b0;
      else if (load)
         last_reg <= req_last[sel_idx];
   end

   // Idle timer: cleared on entry to LOCK, counts LOCK cycles without a byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timer_reg <= '0;
      else if (state_reg == HOLD && tx_rdy)
         timer_reg <= '0;
      else if (state_reg == LOCK && !req_vld[gnt_idx] && !timeout_hit)
         timer_reg <= timer_reg + 1'b1;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{req_last, LOCK_TIMEOUT[0]};
`endif

   // Round-robin search: first valid requester at or above ptr, wrapping
   always_comb begin
      logic [IW-1:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IW'((int'(ptr_reg) + k) % NUM_REQ);
         if (!win_found && req_vld[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic and grant release decision
   always_comb begin
      state_next    = state_reg;
      release_grant = 1'b0;
      case (state_reg)
         IDLE: begin
            if (win_found)
               state_next = HOLD;
         end
         HOLD: begin
            if (tx_rdy) begin
`ifdef UART_ARB_PKT_LOCK_EN
               if (!last_reg) begin
                  state_next = LOCK;
               end else begin
                  state_next    = IDLE;
                  release_grant = 1'b1;
               end
`else
               state_next    = IDLE;
               release_grant = 1'b1;
`endif
            end
         end
`ifdef UART_ARB_PKT_LOCK_EN
         LOCK: begin
            if (req_vld[gnt_idx]) begin
               state_next = HOLD;
            end else if (timeout_hit) begin
               state_next    = IDLE;
               release_grant = 1'b1;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs: req_rdy never depends on tx_rdy; silent during reset
   always_comb begin
      req_rdy   = '0;
      load      = 1'b0;
      sel_idx   = win_idx;
      lock_drop = 1'b0;
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  req_rdy[win_idx] = 1'b1;
                  load             = 1'b1;
               end
            end
`ifdef UART_ARB_PKT_LOCK_EN
            LOCK: begin
               sel_idx = gnt_idx;
               if (req_vld[gnt_idx]) begin
                  req_rdy[gnt_idx] = 1'b1;
                  load             = 1'b1;
               end else begin
                  lock_drop = timeout_hit;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Registered transmitter side, grant index, busy flag and rr pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_vld  <= 1'b0;
         tx_data <= 8'h00;
         gnt_idx <= '0;
         busy    <= 1'b0;
         ptr_reg <= '0;
      end else begin
         busy <= (state_next != IDLE);
         if (load) begin
            tx_vld  <= 1'b1;
            tx_data <= req_byte[sel_idx];
            gnt_idx <= sel_idx;
         end else if (state_reg == HOLD && tx_rdy) begin
            tx_vld <= 1'b0;
         end
         if (release_grant)
            ptr_reg <= ptr_adv;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=4, LOCK_TIMEOUT=8). Directed
// scenarios plus randomized packet traffic checked against a transaction
// level round-robin model. Adapts to UART_ARB_PKT_LOCK_EN.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int LT = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_vld;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_rdy;
   logic           tx_vld;
   logic [7:0]     tx_data;
   logic           tx_rdy;
   logic [1:0]     gnt_idx;
   logic           busy;
   logic           lock_drop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
      .req_last(req_last), .req_rdy(req_rdy), .tx_vld(tx_vld),
      .tx_data(tx_data), .tx_rdy(tx_rdy), .gnt_idx(gnt_idx),
      .busy(busy), .lock_drop(lock_drop)
   );

   task automatic idle_inputs();
      req_vld  = '0;
      req_data = '0;
      req_last = '0;
      tx_rdy   = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      req_vld = '1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (req_rdy !== 4'b0000) begin
         errors++;
         $display("FAIL reset_rdy_in_rst got %b want 0000", req_rdy);
      end
      rst = 1'b0;
      req_vld = '0;
      #1;
      checks++;
      if (tx_vld !== 1'b0 || tx_data !== 8'h00 || gnt_idx !== 2'd0 ||
          busy !== 1'b0 || lock_drop !== 1'b0 || req_rdy !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got vld=%b data=%h gnt=%0d busy=%b drop=%b rdy=%b want all zero",
                  tx_vld, tx_data, gnt_idx, busy, lock_drop, req_rdy);
      end
   endtask

   task automatic test_single_byte();
      do_reset();
      req_vld = 4'b0100;
      req_data[8*2 +: 8] = 8'hA5;
      req_last = 4'b0100;
      #1;
      checks++;
      if (req_rdy !== 4'b0100) begin
         errors++;
         $display("FAIL single_rdy got %b want 0100", req_rdy);
      end
      @(negedge clk);
      req_vld = '0;
      #1;
      checks++;
      if (tx_vld !== 1'b1 || tx_data !== 8'hA5 || gnt_idx !== 2'd2 || busy !== 1'b1 || req_rdy !== 4'b0000) begin
         errors++;
         $display("FAIL single_hold got vld=%b data=%h gnt=%0d busy=%b rdy=%b want 1 a5 2 1 0000",
                  tx_vld, tx_data, gnt_idx, busy, req_rdy);
      end
      @(negedge clk);
      #1;
      checks++;
      if (tx_vld !== 1'b0 || busy !== 1'b0 || tx_data !== 8'hA5) begin
         errors++;
         $display("FAIL single_after got vld=%b busy=%b data=%h want 0 0 a5", tx_vld, busy, tx_data);
      end
      // pointer should now be 3: requester 3 beats requester 0
      req_vld = 4'b1001;
      req_data[8*0 +: 8] = 8'h00;
      req_data[8*3 +: 8] = 8'h3C;
      req_last = 4'b1001;
      #1;
      checks++;
      if (req_rdy !== 4'b1000) begin
         errors++;
         $display("FAIL single_ptr got rdy=%b want 1000", req_rdy);
      end
      @(negedge clk);
      req_vld = '0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int n;
      int cyc;
      do_reset();
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
      req_vld  = '1;
      req_last = '1;
      tx_rdy   = 1'b1;
      n   = 0;
      cyc = 0;
      while (n < 5 && cyc < 40) begin
         #1;
         if (tx_vld && tx_rdy) begin
            $display("rr tx idx %0d data %02h", gnt_idx, tx_data);
            checks++;
            if (gnt_idx !== 2'(n % N) || tx_data !== 8'h10 + 8'(n % N)) begin
               errors++;
               $display("FAIL rr_order[%0d] got gnt=%0d data=%h want gnt=%0d data=%h",
                        n, gnt_idx, tx_data, n % N, 8'h10 + 8'(n % N));
            end
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      req_vld = '0;
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL rr_timeout got %0d bytes want 5", n);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int bad;
      do_reset();
      tx_rdy = 1'b0;
      req_vld = 4'b0010;
      req_data[8*1 +: 8] = 8'h5C;
      req_last = '1;
      #1;
      checks++;
      if (req_rdy !== 4'b0010) begin
         errors++;
         $display("FAIL bp_grant got rdy=%b want 0010", req_rdy);
      end
      @(negedge clk);
      req_vld = 4'b1111;
      for (int c = 0; c < 50; c++) begin
         #1;
         bad = (tx_vld !== 1'b1 || tx_data !== 8'h5C || req_rdy !== 4'b0000 || busy !== 1'b1);
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL bp_stall[%0d] got vld=%b data=%h rdy=%b busy=%b want 1 5c 0000 1",
                     c, tx_vld, tx_data, req_rdy, busy);
         end
         @(negedge clk);
      end
      tx_rdy  = 1'b1;
      req_vld = '0;
      #1;
      checks++;
      if (tx_vld !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got vld=%b want 1", tx_vld);
      end
      @(negedge clk);
      #1;
      checks++;
      if (tx_vld !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept got vld=%b busy=%b want 0 0", tx_vld, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_lock();
      logic [1:0] exp_idx [5];
      logic [7:0] exp_dat [5];
      int k;
      int n;
`ifdef UART_ARB_PKT_LOCK_EN
      exp_idx = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
      exp_dat = '{8'h01, 8'h02, 8'h03, 8'hE0, 8'hE0};
`else
      exp_idx = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
      exp_dat = '{8'h01, 8'hE0, 8'h02, 8'hE0, 8'h03};
`endif
      do_reset();
      tx_rdy = 1'b1;
      k = 0;
      n = 0;
      for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
         req_vld[1]         = (k < 3);
         req_data[8*1 +: 8] = 8'(k + 1);
         req_last[1]        = (k == 2);
         req_vld[0]         = (cyc >= 1);
         req_data[8*0 +: 8] = 8'hE0;
         req_last[0]        = 1'b1;
         #1;
         if (req_rdy[1]) k++;
         if (tx_vld && tx_rdy) begin
            checks++;
            if (gnt_idx !== exp_idx[n] || tx_data !== exp_dat[n]) begin
               errors++;
               $display("FAIL lock_seq[%0d] got gnt=%0d data=%h want gnt=%0d data=%h",
                        n, gnt_idx, tx_data, exp_idx[n], exp_dat[n]);
            end
            n++;
         end
         @(negedge clk);
      end
      req_vld = '0;
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL lock_timeout got %0d bytes want 5", n);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int drop_at;
      int drops;
      do_reset();
      tx_rdy = 1'b1;
      req_vld = 4'b1000;
      req_data[8*3 +: 8] = 8'h33;
      req_last = 4'b0000;
      #1;
      checks++;
      if (req_rdy !== 4'b1000) begin
         errors++;
         $display("FAIL to_grant got rdy=%b want 1000", req_rdy);
      end
      @(negedge clk);
`ifdef UART_ARB_PKT_LOCK_EN
      // requester 0 asks during LOCK and must be ignored
      req_vld = 4'b0001;
      req_data[8*0 +: 8] = 8'h44;
      req_last = 4'b0001;
      @(negedge clk);
      drop_at = 0;
      drops   = 0;
      for (int k = 1; k <= 20 && drop_at == 0; k++) begin
         #1;
         checks++;
         if (req_rdy !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_lock_cycle[%0d] got rdy=%b busy=%b want 0000 1", k, req_rdy, busy);
         end
         if (lock_drop) begin
            drop_at = k;
            drops++;
         end
         @(negedge clk);
      end
      checks++;
      if (drop_at != LT) begin
         errors++;
         $display("FAIL to_drop_cycle got %0d want %0d", drop_at, LT);
      end
      req_vld = 4'b1001;
      req_data[8*3 +: 8] = 8'h34;
      req_last = 4'b1001;
      #1;
      checks++;
      if (busy !== 1'b0 || lock_drop !== 1'b0 || req_rdy !== 4'b0001) begin
         errors++;
         $display("FAIL to_after got busy=%b drop=%b rdy=%b want 0 0 0001", busy, lock_drop, req_rdy);
      end
`else
      req_vld = '0;
      drops = 0;
      drop_at = 0;
      for (int k = 1; k <= 12; k++) begin
         #1;
         if (lock_drop) drops++;
         if (busy && k > 1) drop_at++;
         @(negedge clk);
      end
      checks++;
      if (drops != 0 || drop_at != 0) begin
         errors++;
         $display("FAIL to_nolock got drops=%0d busy_cycles=%0d want 0 0", drops, drop_at);
      end
`endif
      @(negedge clk);
      req_vld = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      tx_rdy = 1'b0;
      req_vld = 4'b0100;
      req_data[8*2 +: 8] = 8'hC3;
      req_last = '1;
      @(negedge clk);
      req_vld = '0;
      #1;
      checks++;
      if (tx_vld !== 1'b1 || gnt_idx !== 2'd2 || tx_data !== 8'hC3) begin
         errors++;
         $display("FAIL rmid_setup got vld=%b gnt=%0d data=%h want 1 2 c3", tx_vld, gnt_idx, tx_data);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (tx_vld !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || gnt_idx !== 2'd0) begin
         errors++;
         $display("FAIL rmid_async got vld=%b data=%h busy=%b gnt=%0d want 0 00 0 0",
                  tx_vld, tx_data, busy, gnt_idx);
      end
      @(negedge clk);
      rst = 1'b0;
      tx_rdy = 1'b1;
      req_vld = 4'b1010;
      #1;
      checks++;
      if (req_rdy !== 4'b0010) begin
         errors++;
         $display("FAIL rmid_first got rdy=%b want 0010", req_rdy);
      end
      @(negedge clk);
      req_vld = '0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [8:0] src_mem [N][16];
      int         src_len [N];
      int         src_rd  [N];
      int         mrd     [N];
      logic [9:0] exp_q [$];
      logic [9:0] e;
      logic [8:0] b;
      int         ptr, w, c, npk, len, cyc, got;
      logic       prev_pend;
      logic [7:0] prev_data;

      do_reset();
      for (int i = 0; i < N; i++) begin
         src_len[i] = 0;
         src_rd[i]  = 0;
         npk = $urandom_range(0, 4);
         for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) begin
               src_mem[i][src_len[i]] = {(j == len - 1), 8'($urandom)};
               src_len[i]++;
            end
         end
      end
      // reference: round-robin over non-empty sources, packet or byte granularity
      for (int i = 0; i < N; i++) mrd[i] = 0;
      ptr = 0;
      while (1) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (w < 0 && mrd[c] < src_len[c]) w = c;
         end
         if (w < 0) break;
`ifdef UART_ARB_PKT_LOCK_EN
         do begin
            b = src_mem[w][mrd[w]];
            mrd[w]++;
            exp_q.push_back({2'(w), b[7:0]});
         end while (!b[8]);
`else
         b = src_mem[w][mrd[w]];
         mrd[w]++;
         exp_q.push_back({2'(w), b[7:0]});
`endif
         ptr = (w + 1) % N;
      end

      got = 0;
      prev_pend = 1'b0;
      prev_data = 8'h00;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 3000) begin
         for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_len[i]) begin
               req_vld[i]         = 1'b1;
               req_data[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
               req_last[i]        = src_mem[i][src_rd[i]][8];
            end else begin
               req_vld[i]         = 1'b0;
               req_data[8*i +: 8] = 8'h00;
               req_last[i]        = 1'b0;
            end
         end
         tx_rdy = 1'($urandom_range(0, 1));
         #1;
         if (prev_pend) begin
            checks++;
            if (tx_vld !== 1'b1 || tx_data !== prev_data) begin
               errors++;
               $display("FAIL rnd_stable got vld=%b data=%h want 1 %h", tx_vld, tx_data, prev_data);
            end
         end
         if ($countones(req_rdy) > 1 || lock_drop !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rnd_rdy_drop got rdy=%b drop=%b want onehot0 and 0", req_rdy, lock_drop);
         end
         for (int i = 0; i < N; i++)
            if (req_rdy[i] && src_rd[i] < src_len[i]) src_rd[i]++;
         if (tx_vld && tx_rdy) begin
            e = exp_q.pop_front();
            $display("rnd tx %0d idx %0d data %02h", got, gnt_idx, tx_data);
            checks++;
            if (gnt_idx !== e[9:8] || tx_data !== e[7:0]) begin
               errors++;
               $display("FAIL rnd_byte[%0d] got gnt=%0d data=%h want gnt=%0d data=%h",
                        got, gnt_idx, tx_data, e[9:8], e[7:0]);
            end
            got++;
         end
         prev_pend = tx_vld && !tx_rdy;
         prev_data = tx_data;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rnd_incomplete got %0d bytes outstanding want 0", exp_q.size());
      end
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_round_robin();
      test_backpressure();
      test_lock();
      test_timeout();
      test_reset_mid();
      for (int r = 0; r < 4; r++) test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1);
   end

endmodule
